// File: rtl/aexm_hazard_ctrl.sv
// Operand-forwarding and hazard controller for the aexm pipeline: tracks in-flight
// destinations behind decode, picks the youngest forwarding source and raises stalls.
module aexm_hazard_ctrl #(
  parameter int AW             = 5,
  parameter int FWD_DEPTH      = 2,
  parameter int SW             = 2,
  parameter int MC_LAT         = 3,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          d_en,
  input  logic          d_valid,
  input  logic [AW-1:0] d_ra,
  input  logic [AW-1:0] d_rb,
  input  logic [AW-1:0] d_rd,
  input  logic          d_wr,
  input  logic          d_load,
  input  logic          d_imm,
  input  logic          d_pc,
  input  logic          d_mcyc,
  input  logic          x_skip,
  output logic          a_hit,
  output logic [SW-1:0] a_stg,
  output logic          a_ld,
  output logic          b_hit,
  output logic [SW-1:0] b_stg,
  output logic          b_ld,
  output logic          stall,
  output logic          busy
);

  localparam int CW = 4;
  localparam logic [CW-1:0] C_INIT = (MC_LAT > 1) ? CW'(MC_LAT - 2) : '0;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  logic [FWD_DEPTH-1:0] r_v;
  logic [AW-1:0]        r_rd [FWD_DEPTH];
  logic [FWD_DEPTH-1:0] r_ld;
  state_t               r_state;
  logic [CW-1:0]        r_cnt;

  logic [FWD_DEPTH-1:0] w_v;
  logic                 w_a_any, w_b_any, w_a_ld, w_b_ld;
  logic [SW-1:0]        w_a_idx, w_b_idx;
  logic                 w_a_use, w_b_use;
  logic                 w_a0, w_b0, w_lu, w_busy;

  // A squashed instruction in X can neither forward nor propagate as valid.
  always_comb begin
    w_v    = r_v;
    w_v[0] = r_v[0] & ~x_skip;
  end

  // Scan oldest to youngest so the lowest matching index is the one kept.
  always_comb begin
    w_a_any = 1'b0;
    w_a_idx = '0;
    w_a_ld  = 1'b0;
    w_b_any = 1'b0;
    w_b_idx = '0;
    w_b_ld  = 1'b0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (w_v[i] && (r_rd[i] == d_ra) && (d_ra != '0)) begin
        w_a_any = 1'b1;
        w_a_idx = SW'(i);
        w_a_ld  = r_ld[i];
      end
      if (w_v[i] && (r_rd[i] == d_rb) && (d_rb != '0)) begin
        w_b_any = 1'b1;
        w_b_idx = SW'(i);
        w_b_ld  = r_ld[i];
      end
    end
  end

  assign w_a_use = w_a_any & d_valid & ~d_pc;
  assign w_b_use = w_b_any & d_valid & ~d_imm;

  assign a_hit = w_a_use;
  assign a_stg = w_a_use ? w_a_idx : '0;
  assign a_ld  = w_a_use & w_a_ld;
  assign b_hit = w_b_use;
  assign b_stg = w_b_use ? w_b_idx : '0;
  assign b_ld  = w_b_use & w_b_ld;

  assign w_a0   = w_v[0] & (r_rd[0] == d_ra) & (d_ra != '0) & ~d_pc;
  assign w_b0   = w_v[0] & (r_rd[0] == d_rb) & (d_rb != '0) & ~d_imm;
  assign w_lu   = (LOAD_USE_STALL != 0) & d_valid & r_ld[0] & (w_a0 | w_b0);
  assign w_busy = (r_state == S_BUSY);

  assign busy  = w_busy;
  assign stall = w_lu | w_busy;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_v     <= '0;
      r_ld    <= '0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      for (int i = 0; i < FWD_DEPTH; i++) r_rd[i] <= '0;
    end else begin
      case (r_state)
        S_BUSY: begin
          // The multi-cycle op counts down on every clock; the pipeline stays frozen.
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: begin
          if (d_en) begin
            for (int i = 1; i < FWD_DEPTH; i++) begin
              r_v[i]  <= w_v[i-1];
              r_rd[i] <= r_rd[i-1];
              r_ld[i] <= r_ld[i-1];
            end
            if (w_lu) begin
              r_v[0]  <= 1'b0;
              r_ld[0] <= 1'b0;
            end else begin
              r_v[0]  <= d_valid & d_wr & (d_rd != '0);
              r_rd[0] <= d_rd;
              r_ld[0] <= d_load;
              if (d_valid && d_mcyc && (MC_LAT > 1)) begin
                r_state <= S_BUSY;
                r_cnt   <= C_INIT;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aexm_hazard_ctrl.sv
// Directed vector bench for aexm_hazard_ctrl: default build plus a FWD_DEPTH=1,
// no-load-use-stall, single-cycle variant sharing the same decode inputs.
module tb_aexm_hazard_ctrl;

  logic       gclk = 1'b0;
  logic       grst_n = 1'b0;
  logic       d_en = 1'b0, d_valid = 1'b0;
  logic [4:0] d_ra = '0, d_rb = '0, d_rd = '0;
  logic       d_wr = 1'b0, d_load = 1'b0, d_imm = 1'b0, d_pc = 1'b0, d_mcyc = 1'b0, x_skip = 1'b0;

  logic       a_hit, a_ld, b_hit, b_ld, stall, busy;
  logic [1:0] a_stg, b_stg;
  logic       va_hit, va_ld, vb_hit, vb_ld, vstall, vbusy;
  logic [1:0] va_stg, vb_stg;

  int n_chk = 0;
  int n_fail = 0;

  always #5 gclk = ~gclk;

  aexm_hazard_ctrl dut (
    .gclk(gclk), .grst_n(grst_n), .d_en(d_en), .d_valid(d_valid),
    .d_ra(d_ra), .d_rb(d_rb), .d_rd(d_rd), .d_wr(d_wr), .d_load(d_load),
    .d_imm(d_imm), .d_pc(d_pc), .d_mcyc(d_mcyc), .x_skip(x_skip),
    .a_hit(a_hit), .a_stg(a_stg), .a_ld(a_ld),
    .b_hit(b_hit), .b_stg(b_stg), .b_ld(b_ld),
    .stall(stall), .busy(busy)
  );

  aexm_hazard_ctrl #(.FWD_DEPTH(1), .MC_LAT(1), .LOAD_USE_STALL(0)) dut_v (
    .gclk(gclk), .grst_n(grst_n), .d_en(d_en), .d_valid(d_valid),
    .d_ra(d_ra), .d_rb(d_rb), .d_rd(d_rd), .d_wr(d_wr), .d_load(d_load),
    .d_imm(d_imm), .d_pc(d_pc), .d_mcyc(d_mcyc), .x_skip(x_skip),
    .a_hit(va_hit), .a_stg(va_stg), .a_ld(va_ld),
    .b_hit(vb_hit), .b_stg(vb_stg), .b_ld(vb_ld),
    .stall(vstall), .busy(vbusy)
  );

  typedef struct {
    logic       en, valid;
    logic [4:0] ra, rb, rd;
    logic       wr, ld, imm, pc, mc, skip;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, valid, input logic [4:0] ra, rb, rd,
                              input logic wr, ld, imm, pc, mc, skip,
                              input logic ah, input logic [1:0] as_, input logic al,
                              input logic bh, input logic [1:0] bs, input logic bl,
                              input logic st, bz);
    vec_t r;
    r.en = en; r.valid = valid; r.ra = ra; r.rb = rb; r.rd = rd;
    r.wr = wr; r.ld = ld; r.imm = imm; r.pc = pc; r.mc = mc; r.skip = skip;
    r.exp = {ah, as_, al, bh, bs, bl, st, bz};
    return r;
  endfunction

  function automatic logic [9:0] main_out();
    return {a_hit, a_stg, a_ld, b_hit, b_stg, b_ld, stall, busy};
  endfunction

  function automatic logic [9:0] var_out();
    return {va_hit, va_stg, va_ld, vb_hit, vb_stg, vb_ld, vstall, vbusy};
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (a_hit,a_stg,a_ld,b_hit,b_stg,b_ld,stall,busy)", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic drive(input vec_t t);
    d_en = t.en; d_valid = t.valid; d_ra = t.ra; d_rb = t.rb; d_rd = t.rd;
    d_wr = t.wr; d_load = t.ld; d_imm = t.imm; d_pc = t.pc; d_mcyc = t.mc; x_skip = t.skip;
  endtask

  initial begin
    //              en v  ra  rb  rd wr ld im pc mc sk  ah as al bh bs bl st bz
    tbl.push_back(mk(1,1, 1,  2,  3, 1,0,0,0,0,0,  0,0,0, 0,0,0, 0,0)); // ADD r3
    tbl.push_back(mk(1,1, 3,  3,  4, 1,0,0,0,0,0,  1,0,0, 1,0,0, 0,0)); // ADD r4,r3,r3
    tbl.push_back(mk(1,1, 3,  4,  5, 1,0,0,0,0,0,  1,1,0, 1,0,0, 0,0)); // third consumer
    tbl.push_back(mk(1,1, 5,  5,  6, 1,1,1,0,0,0,  1,0,0, 0,0,0, 0,0)); // LW r6
    tbl.push_back(mk(1,1, 6,  1,  7, 1,0,0,0,0,0,  1,0,1, 0,0,0, 1,0)); // load-use stall
    tbl.push_back(mk(1,1, 6,  1,  7, 1,0,0,0,0,0,  1,1,1, 0,0,0, 0,0)); // reissue after bubble
    tbl.push_back(mk(1,1, 7,  6,  8, 1,0,0,0,0,0,  1,0,0, 0,0,0, 0,0)); // bubble in entry1
    tbl.push_back(mk(1,1, 0,  0,  5, 1,1,1,0,0,0,  0,0,0, 0,0,0, 0,0)); // LW r5
    tbl.push_back(mk(1,1, 5,  8,  9, 1,0,0,0,0,1,  0,0,0, 1,1,0, 0,0)); // x_skip on LW
    tbl.push_back(mk(1,1, 5,  9, 10, 1,0,0,0,0,0,  0,0,0, 1,0,0, 0,0)); // squashed entry1 v=0
    tbl.push_back(mk(1,1,10,  9,  0, 1,0,0,0,0,0,  1,0,0, 1,1,0, 0,0)); // write r0
    tbl.push_back(mk(1,1, 0,  0,  1, 1,0,0,0,0,0,  0,0,0, 0,0,0, 0,0)); // read r0
    tbl.push_back(mk(1,1, 1,  1,  0, 0,0,0,1,0,0,  0,0,0, 1,0,0, 0,0)); // d_pc suppresses A
    tbl.push_back(mk(1,1, 1,  1,  2, 1,0,1,0,0,0,  1,1,0, 0,0,0, 0,0)); // d_imm suppresses B
    tbl.push_back(mk(1,0, 2,  2,  3, 1,0,0,0,0,0,  0,0,0, 0,0,0, 0,0)); // d_valid=0
    tbl.push_back(mk(0,1, 2,  0,  3, 1,0,0,0,0,0,  1,1,0, 0,0,0, 0,0)); // d_en=0 holds
    tbl.push_back(mk(1,1, 2,  0,  3, 1,0,0,0,0,0,  1,1,0, 0,0,0, 0,0)); // still stage 1
    tbl.push_back(mk(1,1, 0,  0,  4, 1,1,1,0,0,0,  0,0,0, 0,0,0, 0,0)); // LW r4
    tbl.push_back(mk(1,1, 3,  4,  5, 1,0,1,0,0,0,  1,1,0, 0,0,0, 0,0)); // imm hides load-use
    tbl.push_back(mk(1,1, 4,  4,  6, 1,0,0,0,0,0,  1,1,1, 1,1,1, 0,0)); // load in entry1
    tbl.push_back(mk(1,1, 0,  0,  7, 1,1,1,0,0,0,  0,0,0, 0,0,0, 0,0)); // LW r7
    tbl.push_back(mk(1,1, 7,  6,  8, 1,0,0,0,1,0,  1,0,1, 1,1,0, 1,0)); // lu beats mcyc
    tbl.push_back(mk(1,1, 7,  6,  8, 1,0,0,0,1,0,  1,1,1, 0,0,0, 0,0)); // mcyc issues
    tbl.push_back(mk(1,1, 8,  7,  9, 1,0,0,0,0,0,  1,0,0, 0,0,0, 1,1)); // busy cycle 1
    tbl.push_back(mk(1,1, 8,  7,  9, 1,0,0,0,0,0,  1,0,0, 0,0,0, 1,1)); // busy cycle 2, frozen
    tbl.push_back(mk(1,1, 8,  7,  9, 1,0,0,0,0,0,  1,0,0, 0,0,0, 0,0)); // resume
    tbl.push_back(mk(1,1, 9,  8,  1, 1,0,0,0,0,0,  1,0,0, 1,1,0, 0,0)); // after resume

    // Reset with random inputs: no entries valid, so every output must be 0.
    for (int k = 0; k < 4; k++) begin
      @(negedge gclk);
      d_en = 1'($urandom); d_valid = 1'($urandom); d_ra = 5'($urandom); d_rb = 5'($urandom);
      d_rd = 5'($urandom); d_wr = 1'($urandom); d_load = 1'($urandom); d_imm = 1'($urandom);
      d_pc = 1'($urandom); d_mcyc = 1'($urandom); x_skip = 1'($urandom);
      #1 chk($sformatf("reset_rand%0d", k), main_out(), 10'b0);
    end
    @(negedge gclk);
    grst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge gclk);
      drive(tbl[k]);
      #1 chk($sformatf("vec%0d", k), main_out(), tbl[k].exp);
    end

    // Reset pulse in the middle of a multi-cycle op.
    @(negedge gclk);
    drive(mk(1,1,0,0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0,0));
    #1 chk("mc_issue", main_out(), 10'b0);
    @(negedge gclk);
    d_valid = 1'b0; d_mcyc = 1'b0;
    #1 chk("mc_busy1", main_out(), 10'b0000000011);
    #2 grst_n = 1'b0;
    #1 chk("mc_async_reset", main_out(), 10'b0);
    @(negedge gclk);
    #1 chk("mc_reset_held", main_out(), 10'b0);
    grst_n = 1'b1;

    // Variant: FWD_DEPTH=1, LOAD_USE_STALL=0, MC_LAT=1.
    @(negedge gclk);
    drive(mk(1,1,1,2,3,1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    #1 chk("v_add_r3", var_out(), 10'b0);
    @(negedge gclk);
    drive(mk(1,1,3,3,4,1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    #1 chk("v_fwd_stg0", var_out(), 10'b1000100000);
    @(negedge gclk);
    drive(mk(1,1,3,3,5,1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    #1 chk("v_depth1_nohit", var_out(), 10'b0);
    @(negedge gclk);
    drive(mk(1,1,0,0,6,1,1,1,0,0,0, 0,0,0,0,0,0,0,0));
    #1 chk("v_lw_r6", var_out(), 10'b0);
    @(negedge gclk);
    drive(mk(1,1,6,1,7,1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    #1 chk("v_load_fwd_nostall", var_out(), 10'b1001000000);
    @(negedge gclk);
    drive(mk(1,1,0,0,8,1,0,0,0,1,0, 0,0,0,0,0,0,0,0));
    #1 chk("v_mcyc_issue", var_out(), 10'b0);
    @(negedge gclk);
    drive(mk(1,1,8,0,9,1,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    #1 chk("v_mcyc_no_busy", var_out(), 10'b1000000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
